branch_predictor: RTL

Parametrised fetch-stage branch predictor for the 5-stage RV32I pipeline: a direct-mapped branch target buffer with per-entry saturating direction counters, plus a circular return address stack (RAS). Sits beside the PC/instruction memory in stage 1 and supplies a predicted next PC the same cycle. It is trained by resolved control-flow reports from stage 2 (branch/jal) and stage 3 (jalr). It replaces the fixed "advance or stall" next-PC policy with a configurable predicted path.

---
 rtl/branch_predictor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with saturating direction counters
// and a circular return address stack, trained by resolved control flow.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [1:0]      upd_kind_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JMP  = 2'b01,
    KIND_CALL = 2'b10,
    KIND_RET  = 2'b11
  } kind_e;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  kind_e              kind_q   [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [XLEN-1:0]    ras_q    [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q;
  logic [CNT_W-1:0]   ras_cnt_q;

  logic [IDX_W-1:0]   fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic               fetch_hit;
  logic [XLEN-1:0]    ras_top;

  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  kind_e              upd_kind;
  logic               upd_en;
  logic               upd_hit;
  logic               upd_eff_taken;
  logic [CTR_W-1:0]   upd_ctr_next;
  logic               ras_push;
  logic               ras_pop;
  logic               unused_bits;

  assign fetch_idx   = fetch_pc_i[IDX_W+1:2];
  assign fetch_tag   = fetch_pc_i[XLEN-1:IDX_W+2];
  assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign ras_top     = ras_q[ras_ptr_q - PTR_W'(1)];
  assign unused_bits = ^fetch_pc_i[1:0];

  assign upd_idx       = upd_pc_i[IDX_W+1:2];
  assign upd_tag       = upd_pc_i[XLEN-1:IDX_W+2];
  assign upd_kind      = kind_e'(upd_kind_i);
  assign upd_en        = rst_i && upd_valid_i;
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_eff_taken = (upd_kind != KIND_BR) || upd_taken_i;
  assign ras_push      = upd_en && (upd_kind == KIND_CALL);
  assign ras_pop       = upd_en && (upd_kind == KIND_RET) && (ras_cnt_q != '0);

  // Returns prefer the RAS top; an empty stack falls back to the stored target.
  always_comb begin
    pred_valid_o  = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = '0;
    if (rst_i && fetch_hit) begin
      pred_valid_o = 1'b1;
      pred_taken_o = (kind_q[fetch_idx] != KIND_BR) || ctr_q[fetch_idx][CTR_W-1];
      if (pred_taken_o) begin
        if ((kind_q[fetch_idx] == KIND_RET) && (ras_cnt_q != '0))
          pred_target_o = ras_top;
        else
          pred_target_o = target_q[fetch_idx];
      end
    end
  end

  always_comb begin
    upd_ctr_next = ctr_q[upd_idx];
    if (upd_taken_i) begin
      if (ctr_q[upd_idx] != CTR_MAX) upd_ctr_next = ctr_q[upd_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[upd_idx] != '0) upd_ctr_next = ctr_q[upd_idx] - CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      valid_q <= '0;
    else if (upd_valid_i && !upd_hit && upd_eff_taken)
      valid_q[upd_idx] <= 1'b1;
  end

  // Entry payload needs no reset: a cleared valid bit hides stale contents.
  always_ff @(posedge clk_i) begin
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_kind == KIND_BR) begin
          ctr_q[upd_idx] <= upd_ctr_next;
          if (upd_taken_i) target_q[upd_idx] <= upd_target_i;
        end else begin
          ctr_q[upd_idx]    <= CTR_MAX;
          target_q[upd_idx] <= upd_target_i;
          kind_q[upd_idx]   <= upd_kind;
        end
      end else if (upd_eff_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        kind_q[upd_idx]   <= upd_kind;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

  // A push onto a full stack lands on the oldest slot; count saturates.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
    end else if (ras_pop) begin
      ras_ptr_q <= ras_ptr_q - PTR_W'(1);
      ras_cnt_q <= ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (ras_push) ras_q[ras_ptr_q] <= upd_pc_i + XLEN'(4);
  end

endmodule
